// File: rtl/loader_pkg.sv
// Shared state encoding and default sizing for the program loader.
package loader_pkg;

    localparam int LOADER_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/strobe_edge.sv
// Rising-edge detector for the byte strobe: a held-high level yields one pulse.
module strobe_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic w_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q <= 1'b0;
        end else begin
            w_q <= level;
        end
    end

    assign pulse = level & ~w_q;

endmodule

// File: rtl/program_loader.sv
// Byte-serial program loader: writes strobed bytes into program memory while holding the CPU in reset.
// Optional LOADER_CHECKSUM_EN adds a running mod-256 checksum output of accepted bytes.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = $clog2(LOADER_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              program_write,
    input  logic [7:0]        program_cmd,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data,
    output logic              mem_write,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   load_count,
    output logic              full,
    output logic              overflow
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              mw_q, mw_d;
    logic [7:0]        md_q, md_d;
    logic [ADDR_W-1:0] ma_q, ma_d;
    logic              strobe;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        cks_q, cks_d;
`endif

    strobe_edge u_strobe_edge (
        .clk   (clk),
        .reset (reset),
        .level (program_write),
        .pulse (strobe)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        mw_d    = 1'b0;
        md_d    = md_q;
        ma_d    = ma_q;
`ifdef LOADER_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    full_d  = 1'b0;
                    ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    cks_d   = 8'h00;
`endif
                end
            end
            LOAD: begin
                if (!load_en) begin
                    state_d = DONE;
                end
                // A strobe coinciding with load_en falling is dropped on purpose.
                if (strobe && load_en && !full_q) begin
                    mw_d    = 1'b1;
                    md_d    = program_cmd;
                    ma_d    = ptr_q;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    full_d  = ((count_q + 1'b1) == FULL_COUNT);
`ifdef LOADER_CHECKSUM_EN
                    cks_d   = cks_q + program_cmd;
`endif
                end else if (strobe && full_q) begin
                    ovf_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            mw_q    <= 1'b0;
            md_q    <= 8'h00;
            ma_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            cks_q   <= 8'h00;
`endif
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            mw_q    <= mw_d;
            md_q    <= md_d;
            ma_q    <= ma_d;
`ifdef LOADER_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    // Reset gates the write strobe and cpu_reset at once so an abort never lands a pending write.
    assign mem_write   = mw_q & ~reset;
    assign cpu_reset   = ~reset & ((state_q != IDLE) | mw_q);
    assign mem_address = ma_q;
    assign mem_data    = md_q;
    assign load_count  = count_q;
    assign full        = full_q;
    assign overflow    = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum    = cks_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: expected writes are queued at stimulus time and popped by a monitor.
module tb_program_loader;
    import loader_pkg::*;

    localparam int AW    = 8;
    localparam int DEPTH = LOADER_DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic          program_write;
    logic [7:0]    program_cmd;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_data;
    logic          mem_write;
    logic          cpu_reset;
    logic [AW:0]   load_count;
    logic          full;
    logic          overflow;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    program_loader #(.ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .program_write (program_write),
        .program_cmd   (program_cmd),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_write     (mem_write),
        .cpu_reset     (cpu_reset),
        .load_count    (load_count),
        .full          (full),
        .overflow      (overflow)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model of the current session
    int   m_count;
    bit   m_ovf;
    int   m_sum;
    int   last_addr;
    int   last_data;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented write must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_mem_write", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", int'(mem_address), mon_e.addr);
                    check("wr_data", int'(mem_data), mon_e.data);
                    check("wr_cpu_reset", int'(cpu_reset), 1);
                end
            end
        end
    end

    task automatic model_strobe(input logic [7:0] b);
        if (m_count < DEPTH) begin
            exp_q.push_back('{addr: m_count % DEPTH, data: int'(b)});
            last_addr = m_count % DEPTH;
            last_data = int'(b);
            m_count++;
            m_sum = (m_sum + int'(b)) % 256;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic strobe_byte(input logic [7:0] b, input int hold);
        program_cmd   = b;
        program_write = 1'b1;
        model_strobe(b);
        repeat (hold) tick();
        program_write = 1'b0;
        program_cmd   = 8'($urandom);
        tick();
    endtask

    task automatic start_session();
        load_en = 1'b1;
        tick();
        m_count = 0;
        m_ovf   = 1'b0;
        m_sum   = 0;
        check("start_load_count", int'(load_count), 0);
        check("start_full", int'(full), 0);
        check("start_overflow", int'(overflow), 0);
        check("start_cpu_reset", int'(cpu_reset), 1);
    endtask

    task automatic end_session();
        load_en = 1'b0;
        tick();
        check("done_cpu_reset", int'(cpu_reset), 1);
        tick();
        check("idle_cpu_reset", int'(cpu_reset), 0);
        repeat (2) tick();
        check("idle_load_count", int'(load_count), m_count);
        check("idle_full", int'(full), int'(m_count == DEPTH));
        check("idle_overflow", int'(overflow), int'(m_ovf));
        check("idle_hold_addr", int'(mem_address), last_addr);
        check("idle_hold_data", int'(mem_data), last_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b1;
        load_en       = 1'b0;
        program_write = 1'b0;
        program_cmd   = 8'h00;
        m_count       = 0;
        m_ovf         = 1'b0;
        m_sum         = 0;
        last_addr     = 0;
        last_data     = 0;
        repeat (2) tick();
        check("rst_mem_write", int'(mem_write), 0);
        check("rst_cpu_reset", int'(cpu_reset), 0);
        check("rst_load_count", int'(load_count), 0);
        check("rst_full", int'(full), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_mem_address", int'(mem_address), 0);
        check("rst_mem_data", int'(mem_data), 0);
        reset = 1'b0;
        tick();
        check("idle_after_rst_cpu_reset", int'(cpu_reset), 0);

        // Three directed bytes
        start_session();
        strobe_byte(8'h1A, 1);
        strobe_byte(8'h2B, 1);
        strobe_byte(8'h3C, 1);
        check("three_load_count", int'(load_count), 3);
        check("three_full", int'(full), 0);
        check("three_cpu_reset", int'(cpu_reset), 1);
        end_session();

        // Strobe held high for five cycles counts once
        start_session();
        strobe_byte(8'($urandom), 5);
        check("held_load_count", int'(load_count), 1);
        end_session();

        // Random bytes, hold lengths and gaps
        for (int s = 0; s < 3; s++) begin
            start_session();
            n = $urandom_range(10, 30);
            for (int i = 0; i < n; i++) begin
                strobe_byte(8'($urandom), $urandom_range(1, 3));
                repeat ($urandom_range(0, 2)) tick();
            end
            check("rand_load_count", int'(load_count), m_count);
            end_session();
        end

        // Fill the whole memory, then one more strobe
        start_session();
        for (int i = 0; i < DEPTH; i++) begin
            strobe_byte(8'($urandom), 1);
            if (i == DEPTH - 2) check("fill_255_full", int'(full), 0);
        end
        check("fill_256_full", int'(full), 1);
        check("fill_256_count", int'(load_count), DEPTH);
        check("fill_256_overflow", int'(overflow), 0);
        strobe_byte(8'($urandom), 1);
        check("fill_257_overflow", int'(overflow), 1);
        check("fill_257_count", int'(load_count), DEPTH);
        check("fill_257_full", int'(full), 1);
        end_session();

        // Strobe coinciding with load_en falling is dropped
        start_session();
        strobe_byte(8'($urandom), 1);
        program_cmd   = 8'($urandom);
        program_write = 1'b1;
        load_en       = 1'b0;
        tick();
        check("drop_mem_write", int'(mem_write), 0);
        check("drop_done_cpu_reset", int'(cpu_reset), 1);
        program_write = 1'b0;
        tick();
        check("drop_idle_cpu_reset", int'(cpu_reset), 0);
        check("drop_load_count", int'(load_count), 1);

        // Reset the cycle after an accepted strobe aborts the write
        start_session();
        program_cmd   = 8'hA5;
        program_write = 1'b1;
        tick();
        reset         = 1'b1;
        program_write = 1'b0;
        load_en       = 1'b0;
        #1;
        check("abort_mem_write", int'(mem_write), 0);
        check("abort_cpu_reset", int'(cpu_reset), 0);
        tick();
        check("abort_mem_write_next", int'(mem_write), 0);
        check("abort_load_count", int'(load_count), 0);
        check("abort_mem_address", int'(mem_address), 0);
        check("abort_mem_data", int'(mem_data), 0);
        check("abort_full", int'(full), 0);
        check("abort_overflow", int'(overflow), 0);
        reset = 1'b0;
        tick();
        check("abort_idle_cpu_reset", int'(cpu_reset), 0);

`ifdef LOADER_CHECKSUM_EN
        start_session();
        check("cks_cleared", int'(checksum), 0);
        strobe_byte(8'hFF, 1);
        strobe_byte(8'h02, 1);
        check("cks_ff_02", int'(checksum), 1);
        check("cks_model", int'(checksum), m_sum);
        end_session();
`endif

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: program memory address width; depth = 2**ADDR_W bytes.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port load_en  input  1  level; high = loading session active.
REQ-005 SHALL have port program_write  input  1  byte strobe; one byte accepted per rising edge.
REQ-006 SHALL have port program_cmd  input  8  instruction byte: opcode [7:4], address [3:0].
REQ-007 SHALL have port mem_address  output  ADDR_W  program memory write address.
REQ-008 SHALL have port mem_data  output  8  program memory write data.
REQ-009 SHALL have port mem_write  output  1  one-cycle program memory write enable.
REQ-010 SHALL have port cpu_reset  output  1  holds the ICU and program counter in reset while loading.
REQ-011 SHALL have port load_count  output  ADDR_W+1  bytes accepted in the current or last session.
REQ-012 SHALL have port full  output  1  memory filled: load_count == 2**ADDR_W.
REQ-013 SHALL have port overflow  output  1  sticky; a strobe arrived while full.

Function
REQ-014 SHALL implement states IDLE, LOAD, DONE.
REQ-015 SHALL go IDLE->LOAD when load_en=1, clear load_count, full, overflow and the write pointer to 0 on that transition.
REQ-016 SHALL go LOAD->DONE when load_en=0; DONE->IDLE unconditionally after exactly 1 cycle.
REQ-017 SHALL register program_write once (w_q) and detect a strobe as program_write & ~w_q; a held-high strobe SHALL count once.
REQ-018 SHALL accept a strobe only in LOAD with load_en=1 and full=0.
REQ-019 On acceptance in cycle N, SHALL assert mem_write in cycle N+1 only, with mem_data = program_cmd sampled in N and mem_address = pointer value in N.
REQ-020 SHALL increment pointer and load_count on each accepted byte; the pointer wraps to 0 after 2**ADDR_W-1 while full asserts.
REQ-021 In LOAD with full=1, a detected strobe SHALL produce no mem_write and SHALL set overflow.
REQ-022 If a strobe and load_en falling occur in the same cycle, SHALL drop the byte, since load_en=0 blocks acceptance.
REQ-023 SHALL assert cpu_reset in LOAD and DONE, and during the write cycle following the last accept; cpu_reset deasserts only in IDLE.
REQ-024 SHALL hold load_count, full and overflow stable in IDLE until the next session.
REQ-025 mem_data and mem_address SHALL hold their last values when mem_write=0.

Reset
REQ-026 On reset=1, SHALL force state IDLE and clear w_q, pointer, load_count, full, overflow, mem_write, mem_data and mem_address to 0.
REQ-027 On reset=1, SHALL drive cpu_reset to 0.
REQ-028 reset mid-session SHALL abort immediately, with no mem_write in the following cycle.

Configuration
REQ-029 With LOADER_CHECKSUM_EN defined, SHALL add output checksum [7:0], the mod-256 sum of accepted bytes, cleared on session start and reset, updated in the same cycle as mem_write.
REQ-030 Without LOADER_CHECKSUM_EN, the checksum port and logic SHALL be absent.

Structure
REQ-031 The state enum loader_state_t and LOADER_DEPTH SHALL live in a shared package loader_pkg; opcode types stay in instructions.
REQ-032 Strobe edge detection SHALL be the sub-module strobe_edge (inputs clk, reset, level; output pulse).

Verification
REQ-033 Bench: load_en=1, three strobes with 0x1A, 0x2B, 0x3C -> mem_write at addr 0,1,2 with those data; load_count=3; full=0.
REQ-034 Bench: program_write held high 5 cycles -> exactly 1 mem_write.
REQ-035 Bench (ADDR_W=8): 256 strobes, then 1 more -> full=1 after the 256th, no 257th mem_write, overflow=1, load_count=256.
REQ-036 Bench: strobe in the same cycle as load_en 1->0 -> no mem_write; DONE for 1 cycle; cpu_reset low on the following cycle.
REQ-037 Bench: reset asserted the cycle after a strobe -> no mem_write; all outputs 0 next cycle.
REQ-038 Bench (LOADER_CHECKSUM_EN): bytes 0xFF, 0x02 -> checksum=0x01.
